// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM with an instruction register and link tracking.
// Macro FETCH_RAS_EN selects a RAS_DEPTH-entry return-address stack; otherwise one link register.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       INSTR_W   = 16,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               call,
  input  logic               ret,
  output logic [ADDR_W-1:0]  link_addr,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_err
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  if (RAS_DEPTH < 32'd2 || (RAS_DEPTH & (RAS_DEPTH - 32'd1)) != 32'd0) begin : g_depth_check
    $error("fetch_sequencer: RAS_DEPTH must be a power of two >= 2");
  end

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   drain_addr_r;
  logic [INSTR_W-1:0]  instr_r;
  logic [ADDR_W-1:0]   instr_pc_r;
  logic [ADDR_W-1:0]   link_s;
  logic [ADDR_W-1:0]   ras_target_s;
  logic [ADDR_W-1:0]   target_s;
  logic                fetch_done_s;
  logic                capture_s;
  logic                do_call_s;

  assign fetch_done_s = (state_r == ST_FETCH) && mem_ack;
  assign capture_s    = fetch_done_s && !redirect;
  assign do_call_s    = redirect && call;
  assign link_s       = instr_pc_r + ADDR_W'(1);

  // Redirect target: popped link for ret, otherwise the supplied address.
  always_comb begin
    target_s = redirect_addr;
    if (ret) begin
      target_s = ras_target_s;
    end else begin
      target_s = redirect_addr;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a redirect without ack must drain the outstanding read.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (redirect) begin
          state_nxt_s = mem_ack ? ST_FETCH : ST_DRAIN;
        end else if (mem_ack) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect || instr_ready) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // FSM output decode; DRAIN keeps presenting the abandoned address.
  always_comb begin
    mem_req     = 1'b1;
    instr_valid = 1'b0;
    mem_addr    = pc_r;
    case (state_r)
      ST_FETCH: begin
        mem_req     = 1'b1;
        instr_valid = 1'b0;
        mem_addr    = pc_r;
      end
      ST_DRAIN: begin
        mem_req     = 1'b1;
        instr_valid = 1'b0;
        mem_addr    = drain_addr_r;
      end
      ST_HOLD: begin
        mem_req     = 1'b0;
        instr_valid = 1'b1;
        mem_addr    = pc_r;
      end
      default: begin
        mem_req     = 1'b1;
        instr_valid = 1'b0;
        mem_addr    = pc_r;
      end
    endcase
  end

  // Program counter, drain address and instruction register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r         <= RESET_PC;
      drain_addr_r <= '0;
      instr_r      <= '0;
      instr_pc_r   <= '0;
    end else begin
      if (redirect) begin
        pc_r <= target_s;
      end else if (fetch_done_s) begin
        pc_r <= pc_r + ADDR_W'(1);
      end else begin
        pc_r <= pc_r;
      end
      if ((state_r == ST_FETCH) && redirect && !mem_ack) begin
        drain_addr_r <= pc_r;
      end else begin
        drain_addr_r <= drain_addr_r;
      end
      if (capture_s) begin
        instr_r    <= mem_rdata;
        instr_pc_r <= pc_r;
      end else begin
        instr_r    <= instr_r;
        instr_pc_r <= instr_pc_r;
      end
    end
  end

  assign instr    = instr_r;
  assign instr_pc = instr_pc_r;

`ifdef FETCH_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] stack_r [RAS_DEPTH];
  logic [PTR_W-1:0]  top_r;
  logic [PTR_W-1:0]  push_ptr_s;
  logic [CNT_W-1:0]  count_r;
  logic              ras_err_r;
  logic              stk_empty_s;
  logic              stk_full_s;
  logic              do_ret_s;

  assign do_ret_s     = redirect && ret;
  assign stk_empty_s  = (count_r == '0);
  assign stk_full_s   = (count_r == CNT_W'(RAS_DEPTH));
  assign push_ptr_s   = top_r + PTR_W'(1);
  assign ras_target_s = stk_empty_s ? RESET_PC : stack_r[top_r];

  // Circular link stack: a push when full overwrites the oldest slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        stack_r[i] <= '0;
      end
      top_r     <= '0;
      count_r   <= '0;
      ras_err_r <= 1'b0;
    end else if (do_call_s && do_ret_s) begin
      if (stk_empty_s) begin
        stack_r[push_ptr_s] <= link_s;
        top_r               <= push_ptr_s;
        count_r             <= CNT_W'(1);
        ras_err_r           <= 1'b1;
      end else begin
        stack_r[top_r] <= link_s;
      end
    end else if (do_call_s) begin
      stack_r[push_ptr_s] <= link_s;
      top_r               <= push_ptr_s;
      if (stk_full_s) begin
        ras_err_r <= 1'b1;
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end else if (do_ret_s) begin
      if (stk_empty_s) begin
        ras_err_r <= 1'b1;
      end else begin
        top_r   <= top_r - PTR_W'(1);
        count_r <= count_r - CNT_W'(1);
      end
    end else begin
      ras_err_r <= ras_err_r;
    end
  end

  assign link_addr = stk_empty_s ? '0 : stack_r[top_r];
  assign ras_empty = stk_empty_s;
  assign ras_full  = stk_full_s;
  assign ras_err   = ras_err_r;
`else
  logic [ADDR_W-1:0] link_r;

  assign ras_target_s = link_r;

  // Single link register: ret reads it without clearing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      link_r <= '0;
    end else if (do_call_s) begin
      link_r <= link_s;
    end else begin
      link_r <= link_r;
    end
  end

  assign link_addr = link_r;
  assign ras_empty = 1'b0;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: randomized stimulus against a transaction-level
// model (expected fetch stream, link stack as a queue); follows FETCH_RAS_EN like the design.
module tb_fetch_sequencer;
  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RPC = 16'h0000;
`ifdef FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mem_req, mem_ack, instr_valid, instr_ready, redirect, call, ret;
  logic ras_empty, ras_full, ras_err;
  logic [AW-1:0] mem_addr, instr_pc, redirect_addr, link_addr;
  logic [IW-1:0] mem_rdata, instr;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] stk [$];
  logic          m_err;
  logic [AW-1:0] m_link;
  logic [AW-1:0] cur_pc;

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .call(call), .ret(ret),
    .link_addr(link_addr), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clock = ~clock;

  function automatic logic [IW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic drive(input bit a, input bit rd, input bit red, input bit c, input bit r,
                       input logic [AW-1:0] addr);
    mem_ack       = a & mem_req;
    mem_rdata     = mem_fn(mem_addr);
    instr_ready   = rd;
    redirect      = red;
    call          = c;
    ret           = r;
    redirect_addr = addr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; call = 1'b0; ret = 1'b0; redirect_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    stk.delete();
    m_err = 1'b0; m_link = '0; cur_pc = '0;
  endtask

  // Park the core in HOLD with instr_pc = a (from FETCH or HOLD).
  task automatic goto(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cur_pc = a;
    total++;
    if ({instr_valid, instr_pc} !== {1'b1, a}) begin
      $display("FAIL goto got valid=%b pc=%h want valid=1 pc=%h", instr_valid, instr_pc, a);
      bad++;
    end
  endtask

  // From HOLD: one flow change (or plain consume when red=0), checked against the model.
  task automatic flow(input bit c, input bit r, input bit red, input logic [AW-1:0] addr);
    logic [AW-1:0] tgt;
    logic [AW-1:0] lk;
    bit e_empty, e_full, e_err;
    lk  = cur_pc + 16'd1;
    tgt = lk;
    if (red) begin
      tgt = addr;
`ifdef FETCH_RAS_EN
      if (r) begin
        if (stk.size() == 0) begin tgt = RPC; m_err = 1'b1; end
        else tgt = stk.pop_back();
      end
      if (c) begin
        stk.push_back(lk);
        if (stk.size() > DEPTH) begin stk.delete(0); m_err = 1'b1; end
      end
`else
      if (r) tgt = m_link;
      if (c) m_link = lk;
`endif
    end
    drive(1'b0, 1'b1, red, c, r, addr);
    e_empty = RAS_ON && (stk.size() == 0);
    e_full  = RAS_ON && (stk.size() == DEPTH);
    e_err   = RAS_ON && m_err;
    total++;
    if ({mem_req, instr_valid, mem_addr} !== {1'b1, 1'b0, tgt}) begin
      $display("FAIL flow_target c=%b r=%b red=%b got req=%b v=%b addr=%h want addr=%h",
               c, r, red, mem_req, instr_valid, mem_addr, tgt);
      bad++;
    end
    total++;
    if ({ras_empty, ras_full, ras_err} !== {e_empty, e_full, e_err}) begin
      $display("FAIL flow_flags got e/f/err=%b%b%b want %b%b%b",
               ras_empty, ras_full, ras_err, e_empty, e_full, e_err);
      bad++;
    end
`ifdef FETCH_RAS_EN
    if (stk.size() != 0) begin
      total++;
      if (link_addr !== stk[$]) begin
        $display("FAIL flow_link got %h want %h", link_addr, stk[$]);
        bad++;
      end
    end
`else
    total++;
    if (link_addr !== m_link) begin
      $display("FAIL flow_link got %h want %h", link_addr, m_link);
      bad++;
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    goto(16'h0010);
    flow(1'b1, 1'b0, 1'b1, 16'h0123);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0777);
    reset = 1'b0;
    #1;
    total++;
    if ({instr_valid, instr, instr_pc, link_addr, ras_empty, ras_full, ras_err} !==
        {1'b0, 16'h0000, 16'h0000, 16'h0000, RAS_ON, 1'b0, 1'b0}) begin
      $display("FAIL reset_async got v=%b i=%h pc=%h lk=%h e/f/err=%b%b%b", instr_valid,
               instr, instr_pc, link_addr, ras_empty, ras_full, ras_err);
      bad++;
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    stk.delete(); m_err = 1'b0; m_link = '0;
    total++;
    if ({mem_req, mem_addr} !== {1'b1, RPC}) begin
      $display("FAIL reset_release got req=%b addr=%h want 1 %h", mem_req, mem_addr, RPC);
      bad++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, RPC, mem_fn(RPC)}) begin
      $display("FAIL reset_nodrain got v=%b pc=%h i=%h", instr_valid, instr_pc, instr);
      bad++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({mem_req, mem_addr} !== {1'b1, 16'(i)}) begin
        $display("FAIL basic_addr got req=%b addr=%h want 1 %h", mem_req, mem_addr, 16'(i));
        bad++;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      total++;
      if ({instr_valid, mem_req, instr_pc, instr} !== {1'b1, 1'b0, 16'(i), mem_fn(16'(i))}) begin
        $display("FAIL basic_instr got v=%b req=%b pc=%h i=%h want pc=%h",
                 instr_valid, mem_req, instr_pc, instr, 16'(i));
        bad++;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
    total++;
    if ({mem_req, instr_valid, mem_addr, instr_pc, instr} !==
        {1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000}) begin
      $display("FAIL fetch_redirect_ack got req=%b v=%b addr=%h pc=%h i=%h",
               mem_req, instr_valid, mem_addr, instr_pc, instr);
      bad++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({instr_valid, mem_req, instr_pc, instr} !== {1'b1, 1'b0, 16'h0005, mem_fn(16'h0005)}) begin
        $display("FAIL hold_stable cyc=%0d got v=%b req=%b pc=%h i=%h",
                 k, instr_valid, mem_req, instr_pc, instr);
        bad++;
      end
      if (k < 3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    total++;
    if ({mem_req, instr_valid, mem_addr} !== {1'b1, 1'b0, 16'h0006}) begin
      $display("FAIL hold_release got req=%b v=%b addr=%h want 1 0 0006",
               mem_req, instr_valid, mem_addr);
      bad++;
    end
  endtask

  task automatic test_drain(input logic [AW-1:0] t1, input bit second, input logic [AW-1:0] t2);
    logic [AW-1:0] tgt;
    tgt = second ? t2 : t1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, (k == 0) || (second && k == 2), 1'b0, 1'b0, (k == 0) ? t1 : t2);
      total++;
      if ({mem_req, instr_valid, mem_addr} !== {1'b1, 1'b0, RPC}) begin
        $display("FAIL drain_wait cyc=%0d got req=%b v=%b addr=%h want addr=%h",
                 k, mem_req, instr_valid, mem_addr, RPC);
        bad++;
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    total++;
    if ({mem_req, instr_valid, mem_addr, instr_pc, instr} !== {1'b1, 1'b0, tgt, 16'h0000, 16'h0000}) begin
      $display("FAIL drain_exit got req=%b v=%b addr=%h pc=%h i=%h want addr=%h",
               mem_req, instr_valid, mem_addr, instr_pc, instr, tgt);
      bad++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, tgt, mem_fn(tgt)}) begin
      $display("FAIL drain_target got v=%b pc=%h i=%h want pc=%h", instr_valid, instr_pc, instr, tgt);
      bad++;
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp_pc, paddr, ppc;
    logic [IW-1:0] pi;
    bit a, r, pv, preq;
    do_reset();
    exp_pc = RPC;
    for (int n = 0; n < 300; n++) begin
      pv = instr_valid; preq = mem_req; paddr = mem_addr; ppc = instr_pc; pi = instr;
      a = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 1) == 1);
      if (preq) begin
        total++;
        if (paddr !== exp_pc) begin
          $display("FAIL stream_addr got %h want %h", paddr, exp_pc);
          bad++;
        end
      end
      drive(a, r, 1'b0, 1'b0, 1'b0, 16'h0000);
      total++;
      if (preq && a) begin
        if ({instr_valid, mem_req, instr_pc, instr} !== {1'b1, 1'b0, exp_pc, mem_fn(exp_pc)}) begin
          $display("FAIL stream_capture got v=%b req=%b pc=%h i=%h want pc=%h",
                   instr_valid, mem_req, instr_pc, instr, exp_pc);
          bad++;
        end
        exp_pc = exp_pc + 16'd1;
      end else if (preq) begin
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, paddr}) begin
          $display("FAIL stream_wait got v=%b req=%b addr=%h want addr=%h",
                   instr_valid, mem_req, mem_addr, paddr);
          bad++;
        end
      end else if (pv && !r) begin
        if ({instr_valid, mem_req, instr_pc, instr} !== {1'b1, 1'b0, ppc, pi}) begin
          $display("FAIL stream_hold got v=%b req=%b pc=%h i=%h want pc=%h",
                   instr_valid, mem_req, instr_pc, instr, ppc);
          bad++;
        end
      end else begin
        if ({instr_valid, mem_req} !== {1'b0, 1'b1}) begin
          $display("FAIL stream_consume got v=%b req=%b want 0 1", instr_valid, mem_req);
          bad++;
        end
      end
    end
  endtask

  task automatic test_ras_directed();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      goto(16'(i * 16));
      flow(1'b1, 1'b0, 1'b1, 16'(16'h0100 * i));
    end
    for (int i = 0; i < 3; i++) begin
      goto(16'(16'h0400 + i));
      flow(1'b0, 1'b1, 1'b1, 16'h0999);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      goto(16'(16'h0040 + 16 * i));
      flow(1'b1, 1'b0, 1'b1, 16'h0200);
    end
    for (int i = 0; i < 5; i++) begin
      goto(16'(16'h0500 + i));
      flow(1'b0, 1'b1, 1'b1, 16'h0888);
    end
  endtask

  task automatic test_ras_random();
    do_reset();
    for (int n = 0; n < 80; n++) begin
      goto(16'($urandom()));
      flow($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           16'($urandom()));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    goto(16'hFFFF);
    flow(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, mem_fn(16'h0000)}) begin
      $display("FAIL wrap_pc got v=%b pc=%h i=%h want pc=0000", instr_valid, instr_pc, instr);
      bad++;
    end
    goto(16'hFFFF);
    flow(1'b1, 1'b0, 1'b1, 16'h0300);
    goto(16'h0007);
    flow(1'b0, 1'b1, 1'b1, 16'h0555);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_drain(16'h0040, 1'b0, 16'h0000);
    test_drain(16'h0040, 1'b1, 16'h0044);
    test_stream();
    test_ras_directed();
    test_ras_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter ADDR_W, default 16, instruction address width.
REQ-002: Parameter INSTR_W, default 16, instruction word width.
REQ-003: Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-004: Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005: clock  input  1  sole clock; all state on rising edge.
REQ-006: reset  input  1  asynchronous, active-low reset.
REQ-007: mem_req  output  1  instruction read request to block RAM.
REQ-008: mem_addr  output  ADDR_W  read address; stable while mem_req high until mem_ack.
REQ-009: mem_ack  input  1  read data valid on mem_rdata this cycle.
REQ-010: mem_rdata  input  INSTR_W  instruction word.
REQ-011: instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-012: instr  output  INSTR_W  held instruction (instruction register).
REQ-013: instr_pc  output  ADDR_W  address of held instruction.
REQ-014: instr_ready  input  1  FSM consumes held instruction.
REQ-015: redirect  input  1  change flow; qualified with redirect_addr, call, ret.
REQ-016: redirect_addr  input  ADDR_W  jump/branch target (ignored when ret).
REQ-017: call  input  1  with redirect: push instr_pc+1 as link.
REQ-018: ret  input  1  with redirect: target is popped link.
REQ-019: link_addr  output  ADDR_W  current top-of-stack / link value.
REQ-020: ras_empty  output  1  no valid link entries.
REQ-021: ras_full  output  1  RAS_DEPTH entries valid.
REQ-022: ras_err  output  1  sticky: overflow or underflow occurred.

Function
REQ-023: States FETCH, DRAIN, HOLD; FETCH drives mem_req=1, mem_addr=pc.
REQ-024: FETCH, mem_ack=1, no redirect: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W), -> HOLD.
REQ-025: HOLD: instr_valid=1, mem_req=0; instr_ready=1 -> FETCH next cycle; else hold all outputs.
REQ-026: Fetch latency: instr_valid rises the cycle after mem_ack; one instruction per 2 cycles minimum with zero-wait memory.
REQ-027: Redirect in HOLD: instr_valid=0 next cycle, pc<=target, -> FETCH; redirect wins over simultaneous instr_ready.
REQ-028: Redirect in FETCH with mem_ack=1: data discarded, pc<=target, stays FETCH.
REQ-029: Redirect in FETCH with mem_ack=0: pc<=target, -> DRAIN; DRAIN keeps mem_req=1, old mem_addr until mem_ack, discards data, -> FETCH.
REQ-030: Redirect in DRAIN: latest target overwrites pc; no further stack effect beyond that redirect's call/ret.
REQ-031: call/ret without redirect are ignored.
REQ-032: call pushes instr_pc+1; push when full drops oldest entry, sets ras_err.
REQ-033: ret target = top entry, pops; ret when empty targets RESET_PC, sets ras_err.
REQ-034: call and ret together: target = top entry, top replaced by instr_pc+1 (depth unchanged; empty case per REQ-033 then push).
REQ-035: pc+1 and instr_pc+1 wrap from all-ones to 0.

Reset
REQ-036: reset low asynchronously forces: state FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, stack empty, ras_empty=1, ras_full=0, ras_err=0, link_addr=0.
REQ-037: mem_req=1, mem_addr=RESET_PC from first cycle after reset release; reset mid-request abandons it without DRAIN.

Configuration
REQ-038: Macro FETCH_RAS_EN defined: RAS_DEPTH-entry stack per REQ-032..034.
REQ-039: FETCH_RAS_EN undefined: single link register; call overwrites it, ret targets it without clearing; ras_empty=0, ras_full=0, ras_err=0 constant; RAS_DEPTH unused.

Verification
REQ-040: Reset, mem_ack every cycle, instr_ready=1 -> mem_addr 0,1,2; instr_pc 0,1,2 each one cycle after ack.
REQ-041: HOLD at instr_pc=5, instr_ready=0 for 3 cycles -> instr_valid, instr stable, mem_req=0.
REQ-042: FETCH pending (ack delayed 3 cycles), redirect to 0x40 -> DRAIN, old data dropped, next mem_addr=0x40.
REQ-043: Calls at instr_pc 0x10,0x20,0x30 then three rets -> targets 0x31,0x21,0x11; ras_empty=1 after.
REQ-044: RAS_DEPTH=4: 5 calls -> ras_full=1, ras_err=1; 5 rets -> 4 valid links then RESET_PC.
REQ-045: Macro undefined: call at 0x10, call at 0x20, ret twice -> both targets 0x21; ras_err=0.
